bus_control: RTL and testbench
==============================

# bus_control

Control and register-write end of the processor's shared 16-bit bus. Fetches a 9-bit instruction from `din`, drives the bus-mux `select` code step by step, and loads R0–R7, the adder operand A and the result register G from the value returned on `bus`. Exports R0–R7 and G packed as `registers_flat` back to the bus mux, closing the datapath loop.

## Interface
- `word`, 16, data/register width
- `k`, 9, registers exported to the mux (R0–R7, G)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  start request; sampled only in T0
- `din`  in  word  instruction word in T0; immediate operand in T1 of `mvi`
- `bus`  in  word  bus value returned by the mux for the current `select`
- `select`  out  4  mux code: 0–7 = R0–R7, 8 = G, 9 = din, 15 = bus cleared
- `registers_flat`  out  word*k  packed {G, R7, …, R0}; R0 at [word-1:0], G at [word*9-1:word*8]
- `done`  out  1  high in the final step of an instruction

## Operation
- Instruction register IR = `din[8:0]` captured in T0 when `run`=1; `din[word-1:9]` ignored. Fields: opcode = IR[8:6], X = IR[5:3], Y = IR[2:0].
- Opcodes: 000 `mv Rx,Ry`; 001 `mvi Rx,#din`; 010 `add Rx,Ry`; 011 `sub Rx,Ry`; 100–111 NOP.
- Step counter states T0–T3; `select`, `done` and all load enables are combinational decodes of state and IR.
- T0: `select`=15, `done`=0. If `run`=1: IR ← din[8:0], go to T1; else stay in T0.
- T1:
  - mv: `select`=Y, Rx ← bus, `done`=1, go to T0.
  - mvi: `select`=9, Rx ← bus, `done`=1, go to T0.
  - add/sub: `select`=X, A ← bus, go to T2.
  - NOP: `select`=15, `done`=1, no write, go to T0.
- T2 (add/sub): `select`=Y, G ← A + bus (add) or A − bus (sub), go to T3.
- T3 (add/sub): `select`=8, Rx ← bus, `done`=1, go to T0.
- Arithmetic is modulo 2^word. No carry or overflow flag. Sub is two's complement.
- X = Y is legal. Example: `add R2,R2` doubles R2, because A is captured in T1 before any write to R2.
- `run` is ignored in T1–T3. With `run` held high, the next fetch occurs in the T0 cycle following `done`.
- A is internal and not exported. G is exported in `registers_flat`.

## Timing
- Reset (asynchronous, active-high) forces:
  - R0–R7 = 0, A = 0, G = 0, IR = 0, state = T0;
  - therefore `select`=15, `done`=0, `registers_flat`=0.
- Reset asserted mid-instruction aborts it. No register write occurs at or after the reset edge.
- All register writes take effect on the `clk` rising edge that ends the step. The written value is visible on `registers_flat` in the following cycle.
- Instruction latency from the T0 fetch edge:
  - mv, mvi, NOP: 2 cycles (T0, T1);
  - add, sub: 4 cycles (T0–T3).
- `done` is high for exactly one cycle per instruction, concurrent with the final write step.
- The bus path is combinational through the mux: `select` → `bus` settles within the same cycle it is sampled.

## Test plan
- Reset: pulse `rst` mid-`add` during T2 → `registers_flat`=0, `select`=15, `done`=0 immediately (asynchronously); G stays 0 after release.
- mvi then mv:
  - `run`=1, din=0x040 (mvi R0), then din=0x1234 in T1 → R0=0x1234, `done`=1 in T1;
  - then din=0x008 (mv R1,R0) → R1=0x1234 after 2 cycles.
- add with wrap: R0=0xFFFF, R1=0x0002; din=0x081 (add R0,R1) → `select` sequence 15, 0, 1, 8; R0=0x0001 after T3; G=0x0001; `done` only in T3.
- sub and aliasing:
  - R2=0x0005, R3=0x0007, din=0x0D3 (sub R2,R3) → R2=0xFFFE;
  - `add R2,R2` with R2=0x0003 → R2=0x0006.
- NOP and run handling: din=0x1C0 (opcode 111) → `done`=1 in T1, no register changes; toggle `run` during T1–T3 of an add → no extra fetch.
- Back-to-back: `run` held high across mvi, add, mv → each fetch occurs in the T0 cycle immediately after the previous `done`; total 2+4+2 cycles.

Source files
------------

// File: rtl/bus_control.sv
// Sequencer and register file for the shared 16-bit processor bus.
// It fetches 9-bit instructions, steps the mux select and writes R0-R7, A and G from the bus.
module bus_control #(
   parameter int WORD = 16,
   parameter int K    = 9
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_run,
   input  logic [WORD-1:0]   i_din,
   input  logic [WORD-1:0]   i_bus,
   output logic [3:0]        o_select,
   output logic [WORD*K-1:0] o_registers_flat,
   output logic              o_done
);

   // state | meaning
   // T0    | idle / fetch: IR <- din[8:0] when run is high
   // T1    | mv/mvi write Rx, add/sub capture A, NOP completes
   // T2    | add/sub: G <- A +/- Ry
   // T3    | add/sub: Rx <- G
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [3:0] SEL_G    = 4'd8;
   localparam logic [3:0] SEL_DIN  = 4'd9;
   localparam logic [3:0] SEL_NONE = 4'd15;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [8:0]        r_ir;
   logic [WORD-1:0]   r_reg [8];
   logic [WORD-1:0]   r_a;
   logic [WORD-1:0]   r_g;

   logic [2:0]        w_opcode;
   logic [2:0]        w_x;
   logic [2:0]        w_y;
   logic              w_ir_load;
   logic              w_rx_load;
   logic              w_a_load;
   logic              w_g_load;
   logic [WORD-1:0]   w_alu;
   logic              w_unused_din;

   assign w_opcode     = r_ir[8:6];
   assign w_x          = r_ir[5:3];
   assign w_y          = r_ir[2:0];
   assign w_unused_din = ^i_din[WORD-1:9];

   // Subtraction is plain two's complement; no flags are kept.
   assign w_alu = (w_opcode == OP_SUB) ? (r_a - i_bus) : (r_a + i_bus);

   always_comb begin
      w_state_nxt = r_state;
      o_select    = SEL_NONE;
      o_done      = 1'b0;
      w_ir_load   = 1'b0;
      w_rx_load   = 1'b0;
      w_a_load    = 1'b0;
      w_g_load    = 1'b0;
      case (r_state)
         T0: begin
            if (i_run) begin
               w_ir_load   = 1'b1;
               w_state_nxt = T1;
            end
         end
         T1: begin
            w_state_nxt = T0;
            case (w_opcode)
               OP_MV: begin
                  o_select  = {1'b0, w_y};
                  w_rx_load = 1'b1;
                  o_done    = 1'b1;
               end
               OP_MVI: begin
                  o_select  = SEL_DIN;
                  w_rx_load = 1'b1;
                  o_done    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  o_select    = {1'b0, w_x};
                  w_a_load    = 1'b1;
                  w_state_nxt = T2;
               end
               default: begin
                  o_done = 1'b1;
               end
            endcase
         end
         T2: begin
            o_select    = {1'b0, w_y};
            w_g_load    = 1'b1;
            w_state_nxt = T3;
         end
         T3: begin
            o_select    = SEL_G;
            w_rx_load   = 1'b1;
            o_done      = 1'b1;
            w_state_nxt = T0;
         end
         default: begin
            w_state_nxt = T0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= T0;
         r_ir    <= '0;
         r_a     <= '0;
         r_g     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ir_load) r_ir <= i_din[8:0];
         if (w_a_load)  r_a  <= i_bus;
         if (w_g_load)  r_g  <= w_alu;
      end
   end

   // A is captured in T1 before any Rx write, so X = Y aliasing needs no special case.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 8; i++) r_reg[i] <= '0;
      end else if (w_rx_load) begin
         r_reg[w_x] <= i_bus;
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_flat
      assign o_registers_flat[g*WORD +: WORD] = r_reg[g];
   end
   assign o_registers_flat[8*WORD +: WORD] = r_g;

endmodule

// File: tb/tb_bus_control.sv
// Self-checking bench for bus_control: models the bus mux and an instruction-level register model.
module tb_bus_control;

   logic         clk = 1'b0;
   logic         rst;
   logic         run;
   logic [15:0]  din;
   logic [15:0]  bus;
   logic [3:0]   select;
   logic [143:0] flat;
   logic         done;

   always #5 clk = ~clk;

   bus_control #(.WORD(16), .K(9)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_run            (run),
      .i_din            (din),
      .i_bus            (bus),
      .o_select         (select),
      .o_registers_flat (flat),
      .o_done           (done)
   );

   always_comb begin
      bus = '0;
      if (select <= 4'd8)      bus = flat[int'(select)*16 +: 16];
      else if (select == 4'd9) bus = din;
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_r [9];

   typedef struct {
      logic [3:0] sel;
      logic       dn;
   } step_t;

   step_t        q_step [$];
   logic [143:0] q_flat [$];

   typedef struct {
      logic [8:0]  ir;
      logic [15:0] imm;
      int          body_run;
   } vec_t;

   function automatic logic [143:0] model_flat();
      logic [143:0] f;
      for (int k = 0; k < 9; k++) f[k*16 +: 16] = m_r[k];
      return f;
   endfunction

   task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      run = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         check("idle_select", 144'(select), 144'd15);
         check("idle_done", 144'(done), 144'd0);
         check("idle_flat", flat, model_flat());
         step_clk();
      end
   endtask

   // body_run: 0 = run low after fetch, 1 = held high, 2 = random toggling
   task automatic exec(input logic [8:0] ir, input logic [15:0] imm, input int body_run);
      logic [2:0]   op, x, y;
      logic [15:0]  g;
      int           n;
      step_t        s;
      logic [143:0] ef;
      op = ir[8:6];
      x  = ir[5:3];
      y  = ir[2:0];
      q_flat.push_back(model_flat());
      q_step.push_back('{sel: 4'd15, dn: 1'b0});
      case (op)
         3'b000: begin
            q_step.push_back('{sel: {1'b0, y}, dn: 1'b1});
            m_r[x] = m_r[y];
            n = 2;
         end
         3'b001: begin
            q_step.push_back('{sel: 4'd9, dn: 1'b1});
            m_r[x] = imm;
            n = 2;
         end
         3'b010, 3'b011: begin
            q_step.push_back('{sel: {1'b0, x}, dn: 1'b0});
            q_step.push_back('{sel: {1'b0, y}, dn: 1'b0});
            q_step.push_back('{sel: 4'd8, dn: 1'b1});
            g = (op == 3'b010) ? m_r[x] + m_r[y] : m_r[x] - m_r[y];
            m_r[8] = g;
            m_r[x] = g;
            n = 4;
         end
         default: begin
            q_step.push_back('{sel: 4'd15, dn: 1'b1});
            n = 2;
         end
      endcase
      for (int i = 0; i < n; i++) begin
         if (i == 0) begin
            run = 1'b1;
            din = {7'($urandom), ir};
         end else begin
            run = (body_run == 2) ? 1'($urandom) : (body_run == 1);
            din = (i == 1) ? imm : 16'($urandom);
         end
         #1;
         if (i == 0) begin
            ef = q_flat.pop_front();
            check("flat_at_fetch", flat, ef);
         end
         if (q_step.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL step_queue: got empty expected entry");
         end else begin
            s = q_step.pop_front();
            check($sformatf("select ir=%h step=%0d", ir, i), 144'(select), 144'(s.sel));
            check($sformatf("done ir=%h step=%0d", ir, i), 144'(done), 144'(s.dn));
         end
         step_clk();
      end
   endtask

   vec_t vecs [14];

   initial begin
      vecs[0]  = '{ir: 9'h040, imm: 16'h1234, body_run: 0};  // mvi R0
      vecs[1]  = '{ir: 9'h008, imm: 16'h0000, body_run: 0};  // mv R1,R0
      vecs[2]  = '{ir: 9'h040, imm: 16'hFFFF, body_run: 0};  // mvi R0
      vecs[3]  = '{ir: 9'h048, imm: 16'h0002, body_run: 0};  // mvi R1
      vecs[4]  = '{ir: 9'h081, imm: 16'h0000, body_run: 0};  // add R0,R1 wraps
      vecs[5]  = '{ir: 9'h050, imm: 16'h0005, body_run: 0};  // mvi R2
      vecs[6]  = '{ir: 9'h058, imm: 16'h0007, body_run: 0};  // mvi R3
      vecs[7]  = '{ir: 9'h0D3, imm: 16'h0000, body_run: 0};  // sub R2,R3
      vecs[8]  = '{ir: 9'h050, imm: 16'h0003, body_run: 0};  // mvi R2
      vecs[9]  = '{ir: 9'h092, imm: 16'h0000, body_run: 0};  // add R2,R2
      vecs[10] = '{ir: 9'h1C0, imm: 16'hBEEF, body_run: 0};  // NOP 111
      vecs[11] = '{ir: 9'h11A, imm: 16'hBEEF, body_run: 2};  // NOP 100
      vecs[12] = '{ir: 9'h0A2, imm: 16'h0000, body_run: 2};  // add R4,R2
      vecs[13] = '{ir: 9'h0ED, imm: 16'h0000, body_run: 2};  // sub R5,R5

      for (int k = 0; k < 9; k++) m_r[k] = '0;
      rst = 1'b1;
      run = 1'b0;
      din = '0;
      #1;
      check("reset_flat", flat, 144'd0);
      check("reset_select", 144'(select), 144'd15);
      check("reset_done", 144'(done), 144'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      for (int v = 0; v < 14; v++) exec(vecs[v].ir, vecs[v].imm, vecs[v].body_run);
      idle(2);

      // back-to-back with run held high: mvi R6, add R7,R6, mv R0,R7
      exec(9'h070, 16'hABCD, 1);
      exec(9'h0BE, 16'h0000, 1);
      exec(9'h007, 16'h0000, 1);
      idle(1);

      // asynchronous reset in T2 of add R0,R1 aborts it
      run = 1'b1;
      din = 16'h0081;
      step_clk();
      run = 1'b0;
      din = 16'h0000;
      step_clk();
      #1;
      check("abort_t2_select", 144'(select), 144'd1);
      rst = 1'b1;
      #1;
      check("abort_flat", flat, 144'd0);
      check("abort_select", 144'(select), 144'd15);
      check("abort_done", 144'(done), 144'd0);
      step_clk();
      rst = 1'b0;
      for (int k = 0; k < 9; k++) m_r[k] = '0;
      idle(3);
      exec(9'h078, 16'h5A5A, 0);
      idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1);
   end

endmodule
